// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one RAM port between N_CORES cores, each with an icache
//            read port and a dcache read/write port. Inside a core the dcache
//            has priority over the icache. Across cores, grants rotate
//            round-robin. A dcache grant stays locked for a whole block of
//            BLOCK_WORDS accesses, so one block is never split by another
//            requester.
// Ports    : CLK, RST           - clock (rising edge), synchronous active-high reset
//            iREN/iaddr/iwait   - per-core icache read request, address, stall
//            dREN/dWEN/daddr/
//            dstore/dwait       - per-core dcache request, address, data, stall
//            iload/dload        - RAM read data broadcast to all cores
//            ramREN/ramWEN/
//            ramaddr/ramstore   - shared RAM request
//            ramload/ramstate   - RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//            err_count          - saturating count of ERROR cycles while granted
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int N_CORES     = 2,
    parameter int BLOCK_WORDS = 2,
    parameter int ERRW        = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_CORES-1:0]     iREN,
    input  logic [32*N_CORES-1:0]  iaddr,
    output logic [N_CORES-1:0]     iwait,
    output logic [31:0]            iload,
    input  logic [N_CORES-1:0]     dREN,
    input  logic [N_CORES-1:0]     dWEN,
    input  logic [32*N_CORES-1:0]  daddr,
    input  logic [32*N_CORES-1:0]  dstore,
    output logic [N_CORES-1:0]     dwait,
    output logic [31:0]            dload,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [31:0]            ramaddr,
    output logic [31:0]            ramstore,
    input  logic [31:0]            ramload,
    input  logic [1:0]             ramstate,
    output logic [ERRW-1:0]        err_count
);

    localparam int c_IDX_W  = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int c_BEAT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

    localparam logic [1:0] c_RS_ACCESS = 2'd2;
    localparam logic [1:0] c_RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_D = 2'd1,
        ST_GRANT_I = 2'd2
    } state_t;

    state_t               state_q,   state_d;
    logic [c_IDX_W-1:0]   grant_q,   grant_d;
    logic [c_BEAT_W-1:0]  beat_q,    beat_d;
    logic [c_IDX_W-1:0]   rr_last_q, rr_last_d;
    logic [ERRW-1:0]      err_q,     err_d;

    logic [31:0]          w_iaddr  [N_CORES];
    logic [31:0]          w_daddr  [N_CORES];
    logic [31:0]          w_dstore [N_CORES];
    logic [N_CORES-1:0]   w_d_req;
    logic                 w_g_dreq;
    logic                 w_g_ireq;
    logic                 w_pick_valid;
    logic                 w_pick_d;
    logic [c_IDX_W-1:0]   w_pick_idx;
    logic [c_IDX_W-1:0]   w_cand;
    logic                 w_access;

    // Split the flat per-core buses into per-core words.
    for (genvar k = 0; k < N_CORES; k++) begin : g_unpack
        assign w_iaddr[k]  = iaddr[32*k +: 32];
        assign w_daddr[k]  = daddr[32*k +: 32];
        assign w_dstore[k] = dstore[32*k +: 32];
    end

    assign w_d_req  = dREN | dWEN;
    assign w_g_dreq = w_d_req[grant_q];
    assign w_g_ireq = iREN[grant_q];
    assign w_access = (ramstate == c_RS_ACCESS);

    assign iload     = ramload;
    assign dload     = ramload;
    assign err_count = err_q;

    // Round-robin scan starting after the last served core. Every dcache
    // request is considered before any icache request.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_d     = 1'b0;
        w_pick_idx   = '0;
        w_cand       = '0;
        for (int j = 0; j < N_CORES; j++) begin
            w_cand = c_IDX_W'((int'(rr_last_q) + 1 + j) % N_CORES);
            if (!w_pick_valid && w_d_req[w_cand]) begin
                w_pick_valid = 1'b1;
                w_pick_d     = 1'b1;
                w_pick_idx   = w_cand;
            end
        end
        for (int j = 0; j < N_CORES; j++) begin
            w_cand = c_IDX_W'((int'(rr_last_q) + 1 + j) % N_CORES);
            if (!w_pick_valid && iREN[w_cand]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = w_cand;
            end
        end
    end

    // RAM request and stalls follow the live request of the granted core, so
    // a request that drops releases the RAM in the same cycle. The address and
    // data buses are zeroed whenever no strobe is driven.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        case (state_q)
            ST_GRANT_D: begin
                if (w_g_dreq) begin
                    // A simultaneous read and write resolves to the write.
                    ramWEN   = dWEN[grant_q];
                    ramREN   = dREN[grant_q] & ~dWEN[grant_q];
                    ramaddr  = w_daddr[grant_q];
                    ramstore = w_dstore[grant_q];
                    if (w_access) begin
                        dwait[grant_q] = 1'b0;
                    end
                end
            end
            ST_GRANT_I: begin
                if (w_g_ireq) begin
                    ramREN  = 1'b1;
                    ramaddr = w_iaddr[grant_q];
                    if (w_access) begin
                        iwait[grant_q] = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        beat_d    = beat_q;
        rr_last_d = rr_last_q;
        err_d     = err_q;

        // ERROR only counts while a strobe is actually presented to the RAM.
        if ((ramREN || ramWEN) && (ramstate == c_RS_ERROR) && (err_q != {ERRW{1'b1}})) begin
            err_d = err_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    state_d = w_pick_d ? ST_GRANT_D : ST_GRANT_I;
                    grant_d = w_pick_idx;
                    beat_d  = '0;
                end
            end
            ST_GRANT_D: begin
                if (!w_g_dreq) begin
                    state_d   = ST_IDLE;
                    beat_d    = '0;
                    rr_last_d = grant_q;
                end else if (w_access) begin
                    if (beat_q == c_BEAT_W'(BLOCK_WORDS - 1)) begin
                        state_d   = ST_IDLE;
                        beat_d    = '0;
                        rr_last_d = grant_q;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_GRANT_I: begin
                if (!w_g_ireq) begin
                    state_d = ST_IDLE;
                end else if (w_access) begin
                    state_d   = ST_IDLE;
                    rr_last_d = grant_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            beat_q    <= '0;
            rr_last_q <= c_IDX_W'(N_CORES - 1);
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            beat_q    <= beat_d;
            rr_last_q <= rr_last_d;
            err_q     <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter (2 cores, 2-word blocks,
//            16-bit error counter): directed scenarios plus a randomized run
//            against a behavioural model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int N  = 2;
    localparam int BW = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  iREN, dREN, dWEN;
    logic [63:0] iaddr, daddr, dstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic [1:0]  iwait, dwait;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        ramREN, ramWEN;
    logic [15:0] err_count;

    int n_total = 0;
    int n_pass  = 0;

    // {REN, WEN, addr, iwait, dwait}
    wire [37:0] obs = {ramREN, ramWEN, ramaddr, iwait, dwait};

    mem_arbiter #(.N_CORES(N), .BLOCK_WORDS(BW), .ERRW(16)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .err_count(err_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1);
    end

    // Inputs change 2 time units after each rising edge; checks sample 1 later.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = 2'd0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        logic [37:0] e;
        do_reset();
        #1;
        e = {1'b0, 1'b0, 32'h0, 2'b11, 2'b11};
        n_total++;
        if (obs !== e) $display("FAIL reset_outputs: got %h want %h", obs, e);
        else n_pass++;
        n_total++;
        if ({ramstore, err_count} !== 48'h0) $display("FAIL reset_store_err: got %h/%h want 0/0", ramstore, err_count);
        else n_pass++;
    endtask

    task automatic test_icache_read();
        logic [37:0] e;
        do_reset();
        iREN = 2'b01; iaddr[31:0] = 32'h40; ramstate = 2'd0;
        #1;
        e = {1'b0, 1'b0, 32'h0, 2'b11, 2'b11};
        n_total++;
        if (obs !== e) $display("FAIL icache_arb_cycle: got %h want %h", obs, e);
        else n_pass++;
        tick();
        ramstate = 2'd1;
        #1;
        e = {1'b1, 1'b0, 32'h40, 2'b11, 2'b11};
        n_total++;
        if (obs !== e) $display("FAIL icache_busy: got %h want %h", obs, e);
        else n_pass++;
        tick();
        ramstate = 2'd2; ramload = 32'hDEADBEEF;
        #1;
        e = {1'b1, 1'b0, 32'h40, 2'b11, 2'b10};
        e[3:0] = 4'b1011;
        n_total++;
        if (obs !== e || iload !== 32'hDEADBEEF) $display("FAIL icache_access: got %h load %h want %h load deadbeef", obs, iload, e);
        else n_pass++;
        tick();
        iREN = 2'b00; ramstate = 2'd0;
        #1;
        e = {1'b0, 1'b0, 32'h0, 2'b11, 2'b11};
        n_total++;
        if (obs !== e) $display("FAIL icache_back_idle: got %h want %h", obs, e);
        else n_pass++;
    endtask

    task automatic test_d_over_i();
        logic [37:0] e;
        do_reset();
        iREN = 2'b01; iaddr[31:0] = 32'h40;
        dREN = 2'b01; daddr[31:0] = 32'h100; ramstate = 2'd2;
        tick();
        #1;
        e = {1'b1, 1'b0, 32'h100, 2'b11, 2'b10};
        n_total++;
        if (obs !== e) $display("FAIL d_over_i_beat0: got %h want %h", obs, e);
        else n_pass++;
        tick();
        daddr[31:0] = 32'h104;
        #1;
        e = {1'b1, 1'b0, 32'h104, 2'b11, 2'b10};
        n_total++;
        if (obs !== e) $display("FAIL d_over_i_beat1: got %h want %h", obs, e);
        else n_pass++;
        tick();
        dREN = 2'b00;
        tick();
        #1;
        e = {1'b1, 1'b0, 32'h40, 2'b10, 2'b11};
        n_total++;
        if (obs !== e) $display("FAIL d_over_i_icache_after: got %h want %h", obs, e);
        else n_pass++;
    endtask

    task automatic test_block_lock();
        logic [37:0] e;
        do_reset();
        dWEN = 2'b01; daddr[31:0] = 32'h200; dstore[31:0] = 32'h11111111;
        iREN = 2'b10; iaddr[63:32] = 32'h300; ramstate = 2'd2;
        tick();
        #1;
        e = {1'b0, 1'b1, 32'h200, 2'b11, 2'b10};
        n_total++;
        if (obs !== e || ramstore !== 32'h11111111) $display("FAIL lock_beat0: got %h/%h want %h/11111111", obs, ramstore, e);
        else n_pass++;
        tick();
        daddr[31:0] = 32'h204; dstore[31:0] = 32'h22222222;
        #1;
        e = {1'b0, 1'b1, 32'h204, 2'b11, 2'b10};
        n_total++;
        if (obs !== e || ramstore !== 32'h22222222) $display("FAIL lock_beat1: got %h/%h want %h/22222222", obs, ramstore, e);
        else n_pass++;
        tick();
        dWEN = 2'b00;
        #1;
        e = {1'b0, 1'b0, 32'h0, 2'b11, 2'b11};
        n_total++;
        if (obs !== e) $display("FAIL lock_release_idle: got %h want %h", obs, e);
        else n_pass++;
        tick();
        #1;
        e = {1'b1, 1'b0, 32'h300, 2'b01, 2'b11};
        n_total++;
        if (obs !== e) $display("FAIL lock_core1_icache: got %h want %h", obs, e);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [31:0] ea [9] = '{32'h0, 32'hA00, 32'hA00, 32'h0, 32'hB00, 32'hB00, 32'h0, 32'hA00, 32'hA00};
        logic [1:0]  ew [9] = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10};
        logic [37:0] e;
        do_reset();
        dREN = 2'b11; daddr = {32'hB00, 32'hA00}; ramstate = 2'd2;
        for (int c = 0; c < 9; c++) begin
            #1;
            e = {ea[c] != 32'h0, 1'b0, ea[c], 2'b11, ew[c]};
            n_total++;
            if (obs !== e) $display("FAIL round_robin_c%0d: got %h want %h", c, obs, e);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_error_retry();
        logic [37:0] e;
        int pulses;
        do_reset();
        pulses = 0;
        dREN = 2'b01; daddr[31:0] = 32'h500; ramstate = 2'd3;
        tick();
        #1;
        n_total++;
        if (err_count !== 16'd0) $display("FAIL err_idle_not_counted: got %0d want 0", err_count);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            e = {1'b1, 1'b0, 32'h500, 2'b11, 2'b11};
            n_total++;
            if (obs !== e) $display("FAIL err_retry_hold_c%0d: got %h want %h", c, obs, e);
            else n_pass++;
            if (dwait[0] == 1'b0) pulses++;
            tick();
            #1;
        end
        ramstate = 2'd2;
        #1;
        if (dwait[0] == 1'b0) pulses++;
        n_total++;
        if (err_count !== 16'd3 || pulses != 1) $display("FAIL err_count3: got count %0d pulses %0d want 3 and 1", err_count, pulses);
        else n_pass++;
        tick();
        dREN = 2'b00; ramstate = 2'd0;
        tick();
        #1;
        n_total++;
        if (err_count !== 16'd3) $display("FAIL err_count_hold: got %0d want 3", err_count);
        else n_pass++;
    endtask

    task automatic test_saturate();
        logic [37:0] e;
        do_reset();
        dREN = 2'b01; daddr[31:0] = 32'h540; ramstate = 2'd3;
        for (int c = 0; c < 65540; c++) tick();
        #1;
        e = {1'b1, 1'b0, 32'h540, 2'b11, 2'b11};
        n_total++;
        if (err_count !== 16'hFFFF || obs !== e) $display("FAIL err_saturate: got %h/%h want ffff/%h", err_count, obs, e);
        else n_pass++;
        tick(); tick(); tick();
        #1;
        n_total++;
        if (err_count !== 16'hFFFF) $display("FAIL err_saturate_hold: got %h want ffff", err_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid_block();
        logic [37:0] e;
        do_reset();
        iREN = 2'b01; iaddr[31:0] = 32'h80; ramstate = 2'd2;
        tick();
        #1;
        e = {1'b1, 1'b0, 32'h80, 2'b10, 2'b11};
        n_total++;
        if (obs !== e) $display("FAIL rmb_icache_core0: got %h want %h", obs, e);
        else n_pass++;
        tick();
        iREN = 2'b00; dWEN = 2'b10; daddr[63:32] = 32'h600; ramstate = 2'd3;
        tick();
        tick();
        ramstate = 2'd2;
        #1;
        e = {1'b0, 1'b1, 32'h600, 2'b11, 2'b01};
        n_total++;
        if (obs !== e || err_count !== 16'd1) $display("FAIL rmb_core1_beat0: got %h err %0d want %h err 1", obs, err_count, e);
        else n_pass++;
        tick();
        RST = 1'b1; ramstate = 2'd1; dREN = 2'b01; daddr[31:0] = 32'h700;
        tick();
        RST = 1'b0; ramstate = 2'd2;
        #1;
        e = {1'b0, 1'b0, 32'h0, 2'b11, 2'b11};
        n_total++;
        if (obs !== e || err_count !== 16'd0) $display("FAIL rmb_after_reset: got %h err %0d want %h err 0", obs, err_count, e);
        else n_pass++;
        tick();
        #1;
        e = {1'b1, 1'b0, 32'h700, 2'b11, 2'b10};
        n_total++;
        if (obs !== e) $display("FAIL rmb_core0_first: got %h want %h", obs, e);
        else n_pass++;
    endtask

    // Reference: an owner (-1 = nobody), its kind, completed beats, the last
    // core served and the error tally, advanced once per clock.
    task automatic test_random();
        int m_owner, m_beats, m_last, m_err, g, pick, r;
        bit m_d, pick_d, req;
        logic        x_ren, x_wen;
        logic [31:0] x_addr, x_store;
        logic [1:0]  x_iw, x_dw;
        int errs;
        do_reset();
        m_owner = -1; m_beats = 0; m_last = N - 1; m_err = 0; m_d = 1'b0;
        errs = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(5) == 0) iREN[k] = ~iREN[k];
                if ($urandom_range(5) == 0) dREN[k] = ~dREN[k];
                if ($urandom_range(7) == 0) dWEN[k] = ~dWEN[k];
            end
            iaddr = {$urandom, $urandom};
            daddr = {$urandom, $urandom};
            dstore = {$urandom, $urandom};
            ramload = $urandom;
            r = $urandom_range(99);
            ramstate = (r < 50) ? 2'd2 : (r < 70) ? 2'd0 : (r < 85) ? 2'd1 : 2'd3;
            #1;
            x_ren = 1'b0; x_wen = 1'b0; x_addr = '0; x_store = '0;
            x_iw = 2'b11; x_dw = 2'b11; req = 1'b0; g = m_owner;
            if (m_owner >= 0) begin
                if (m_d) begin
                    req = dREN[g] | dWEN[g];
                    if (req) begin
                        x_wen = dWEN[g];
                        x_ren = ~dWEN[g];
                        x_addr = daddr[32*g +: 32];
                        x_store = dstore[32*g +: 32];
                        if (ramstate == 2'd2) x_dw[g] = 1'b0;
                    end
                end else begin
                    req = iREN[g];
                    if (req) begin
                        x_ren = 1'b1;
                        x_addr = iaddr[32*g +: 32];
                        if (ramstate == 2'd2) x_iw[g] = 1'b0;
                    end
                end
            end
            n_total++;
            if ({ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload, err_count} !==
                {x_ren, x_wen, x_addr, x_store, x_iw, x_dw, ramload, ramload, 16'(m_err)}) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random_c%0d: got ren%b wen%b a%h s%h iw%b dw%b e%0d want ren%b wen%b a%h s%h iw%b dw%b e%0d",
                             c, ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, err_count,
                             x_ren, x_wen, x_addr, x_store, x_iw, x_dw, m_err);
            end else n_pass++;
            if (m_owner < 0) begin
                pick = -1; pick_d = 1'b0;
                for (int j = 0; j < N; j++)
                    if (pick < 0 && (dREN[(m_last + 1 + j) % N] | dWEN[(m_last + 1 + j) % N])) begin
                        pick = (m_last + 1 + j) % N; pick_d = 1'b1;
                    end
                for (int j = 0; j < N; j++)
                    if (pick < 0 && iREN[(m_last + 1 + j) % N]) pick = (m_last + 1 + j) % N;
                if (pick >= 0) begin
                    m_owner = pick; m_d = pick_d; m_beats = 0;
                end
            end else begin
                if (req && ramstate == 2'd3 && m_err < 65535) m_err++;
                if (!req) begin
                    if (m_d) m_last = g;
                    m_owner = -1; m_beats = 0;
                end else if (ramstate == 2'd2) begin
                    if (m_d) begin
                        m_beats++;
                        if (m_beats == BW) begin
                            m_owner = -1; m_last = g; m_beats = 0;
                        end
                    end else begin
                        m_owner = -1; m_last = g;
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_d_over_i();
        test_block_lock();
        test_round_robin();
        test_error_retry();
        test_reset_mid_block();
        test_random();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
